pipe_adder: RTL and testbench
=============================

# pipe_adder

Parametrised, pipelined adder for the datapath. It registers two WIDTH-bit operands and supports four arithmetic modes: wrapping add, saturating add, subtract and running accumulate. Results are returned through a valid/ready handshake after a configurable number of pipeline stages, with a carry/borrow flag. It is the next-generation replacement for the fixed 16-bit registered adder, sitting between operand producers and result consumers that may apply backpressure.

## Interface
Parameters:
- WIDTH, 16, operand and result width in bits (>= 2)
- STAGES, 2, latency in cycles from accepted input to out_valid (>= 1)

Ports:
- clk  input  1  single clock; all state updates on posedge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept a beat this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B (ignored in accumulate mode)
- in_mode  input  2  00 wrap add, 01 unsigned saturating add, 10 wrap subtract A-B, 11 accumulate
- acc_clr  input  1  synchronous accumulator clear
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_sum  output  WIDTH  result
- out_carry  output  1  carry (add/accumulate), borrow (subtract), would-be carry (saturate)
- stat_xfers  output  32  accepted-input count (see Configuration)
- stat_carries  output  32  count of results with out_carry=1 (see Configuration)

## Operation
- Transfer in: in_valid && in_ready at posedge. Transfer out: out_valid && out_ready at posedge.
- Stall = out_valid && !out_ready. in_ready = !stall (combinational). While stalling, every stage holds, including valid bits and the accumulator.
- The result is computed in the accept cycle. Stage 1 captures the result and flag, and stages 2..STAGES delay it. Each stage carries a valid bit, so bubbles propagate.
- Arithmetic uses a (WIDTH+1)-bit internal sum:
  - 00: sum = a+b mod 2^WIDTH; carry = bit WIDTH.
  - 01: if a+b >= 2^WIDTH, sum = all ones and carry = 1; else same as 00.
  - 10: sum = a-b mod 2^WIDTH; carry = 1 iff a < b.
  - 11: sum = acc+a mod 2^WIDTH; carry = wrap; acc <= sum on accept.
- acc updates only on an accepted mode-11 beat, or on acc_clr.
- acc_clr with no accepted mode-11 beat: acc <= 0 at the next posedge, whether or not the block is stalled.
- acc_clr in the same cycle as an accepted mode-11 beat: the clear applies first. Then sum = a, carry = 0, acc <= a.
- No state machine beyond the per-stage valid bits and the accumulator.

## Timing
- Reset (async assert, sync-safe release): all stage valids 0, out_valid 0, out_sum 0, out_carry 0, acc 0, in_ready 1, stat counters 0.
- Latency: a beat accepted at posedge N gives out_valid=1 after posedge N+STAGES-1, visible in cycle N+STAGES, absent stalls.
- Throughput: one beat per cycle while out_ready = 1.
- out_sum and out_carry stay stable while out_valid && !out_ready.
- Reset asserted mid-stream: all in-flight beats are discarded with no partial output, and acc returns to 0.
- in_mode, in_a and in_b are sampled only on accept. Changes while in_ready = 0 have no effect.

## Configuration
- Macro PIPE_ADDER_STATS_EN.
- Defined: stat_xfers increments per accepted input beat. stat_carries increments per output transfer with out_carry = 1. Both are 32-bit wrapping counters, reset to 0.
- Undefined: the counters are not built, and stat_xfers and stat_carries are tied to 0. Ports stay present in both builds.

## Test plan
Defaults for all scenarios: WIDTH=16, STAGES=2.
- Wrap add: mode 00, A=0xFFFF, B=0x0001 accepted at cycle 0 -> out_valid in cycle 2, sum 0x0000, carry 1.
- Saturate and subtract: mode 01 with 0xFFF0+0x0020 -> 0xFFFF, carry 1. Mode 10 with 0x0005-0x0007 -> 0xFFFE, carry 1. Mode 10 with 0x0007-0x0005 -> 0x0002, carry 0.
- Accumulate: pulse acc_clr, then three mode-11 beats of A=0x1000 -> 0x1000, 0x2000, 0x3000. A fourth beat with acc_clr asserted -> 0x1000.
- Backpressure: 6 back-to-back beats (A=1..6, B=0, mode 00). Drop out_ready for 3 cycles after the first out_valid -> in_ready low exactly during the stall, outputs 1..6 in order with no loss or duplication.
- Reset mid-stream: assert rst_n=0 with 2 beats in flight -> out_valid 0 immediately. After release, no stale results appear and the first new beat returns with normal latency.
- Stats (macro defined): 10 accepted beats, 3 with carry -> stat_xfers=10, stat_carries=3. Same test without the macro -> both 0.

Source files
------------

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - pipelined WIDTH-bit adder (wrap/saturate/subtract/accumulate), stats under PIPE_ADDER_STATS_EN
module pipe_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    input  logic [1:0]        in_mode,
    input  logic              acc_clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_sum,
    output logic              out_carry,
    output logic [31:0]       stat_xfers,
    output logic [31:0]       stat_carries
);

    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_SAT = 2'b01;
    localparam logic [1:0] MODE_SUB = 2'b10;
    localparam logic [1:0] MODE_ACC = 2'b11;

    logic [STAGES-1:0] vld;
    logic [WIDTH:0]    stg [STAGES];
    logic [WIDTH-1:0]  acc;
    logic [WIDTH-1:0]  acc_base;
    logic [WIDTH:0]    add_ext;
    logic [WIDTH:0]    sub_ext;
    logic [WIDTH:0]    acc_ext;
    logic [WIDTH:0]    res;
    logic              stall;
    logic              accept;
    logic              acc_beat;

    assign out_valid = vld[STAGES-1];
    assign out_sum   = stg[STAGES-1][WIDTH-1:0];
    assign out_carry = stg[STAGES-1][WIDTH];
    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall;
    assign accept    = in_valid && in_ready;
    assign acc_beat  = accept && (in_mode == MODE_ACC);

    // A clear coinciding with an accumulate beat zeroes the base first.
    assign acc_base = acc_clr ? '0 : acc;
    assign add_ext  = {1'b0, in_a} + {1'b0, in_b};
    assign sub_ext  = {1'b0, in_a} - {1'b0, in_b};
    assign acc_ext  = {1'b0, acc_base} + {1'b0, in_a};

    always_comb begin
        res = add_ext;
        case (in_mode)
            MODE_ADD: res = add_ext;
            MODE_SAT: res = add_ext[WIDTH] ? '1 : add_ext;
            MODE_SUB: res = sub_ext;
            MODE_ACC: res = acc_ext;
            default:  res = add_ext;
        endcase
    end

    // Bit WIDTH of each stage word is the carry/borrow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int i = 0; i < STAGES; i++) begin
                stg[i] <= '0;
            end
        end else if (!stall) begin
            vld[0] <= accept;
            if (accept) begin
                stg[0] <= res;
            end
            for (int i = 1; i < STAGES; i++) begin
                vld[i] <= vld[i-1];
                stg[i] <= stg[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (acc_beat) begin
            acc <= acc_ext[WIDTH-1:0];
        end else if (acc_clr) begin
            acc <= '0;
        end
    end

`ifdef PIPE_ADDER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_xfers   <= '0;
            stat_carries <= '0;
        end else begin
            if (accept) begin
                stat_xfers <= stat_xfers + 32'd1;
            end
            if (out_valid && out_ready && out_carry) begin
                stat_carries <= stat_carries + 32'd1;
            end
        end
    end
`else
    assign stat_xfers   = '0;
    assign stat_carries = '0;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// tb/tb_pipe_adder.sv - scoreboard bench for pipe_adder with randomized and directed stimulus
module tb_pipe_adder;

    localparam int W = 16;
    localparam int S = 2;
    localparam longint M = 64'd1 << W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic [1:0]   in_mode = '0;
    logic         acc_clr = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_sum;
    logic         out_carry;
    logic [31:0]  stat_xfers;
    logic [31:0]  stat_carries;

    pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_carry(out_carry),
        .stat_xfers(stat_xfers), .stat_carries(stat_carries)
    );

    always #5 clk = ~clk;

    int           tests = 0;
    int           fails = 0;
    logic [W:0]   exp_q[$];
    longint       macc = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference arithmetic on unbounded integers; returns {carry, sum}.
    function automatic logic [W:0] model(input int m, input longint a, input longint b, input longint base);
        longint t;
        logic   c;
        longint s;
        case (m)
            0: begin t = a + b; s = t % M; c = (t >= M); end
            1: begin t = a + b; s = (t >= M) ? M - 1 : t; c = (t >= M); end
            2: begin s = (a - b + M) % M; c = (a < b); end
            default: begin t = base + a; s = t % M; c = (t >= M); end
        endcase
        return {c, s[W-1:0]};
    endfunction

    task automatic cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] m, input logic clr, input logic ordy, output logic took);
        logic [W:0] r;
        @(negedge clk);
        in_valid = v; in_a = a; in_b = b; in_mode = m; acc_clr = clr; out_ready = ordy;
        #1;
        took = v && in_ready;
        if (took) begin
            if (m == 2'b11) begin
                r = model(3, a, b, clr ? 0 : macc);
                macc = r[W-1:0];
            end else begin
                r = model(m, a, b, 0);
                if (clr) macc = 0;
            end
            exp_q.push_back(r);
        end else if (clr) begin
            macc = 0;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        acc_clr = 1'b0;
    endtask

    task automatic drain();
        logic took;
        for (int k = 0; k < 30 && exp_q.size() != 0; k++) begin
            cycle(1'b0, '0, '0, 2'b00, 1'b0, 1'b1, took);
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    task automatic latency_beat(input logic [W-1:0] a, input logic [W-1:0] b, input string name);
        logic took;
        cycle(1'b1, a, b, 2'b00, 1'b0, 1'b1, took);
        chk({name, "_accept"}, took, 1);
        for (int k = 0; k < S; k++) begin
            @(negedge clk);
            #1;
            chk({name, "_latency"}, out_valid, (k == S - 1) ? 1 : 0);
            if (k < S - 1) @(posedge clk);
        end
    endtask

    // Monitor: pops the scoreboard on every output transfer.
    initial begin : monitor
        logic [W:0] e;
        logic       prev_stall = 1'b0;
        logic [W:0] prev_out = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
                if (prev_stall && out_valid)
                    chk("stall_hold", {out_carry, out_sum}, prev_out);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", {out_carry, out_sum}, -1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("result", {out_carry, out_sum}, e);
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_out = {out_carry, out_sum};
            end
        end
    end

    initial begin
        logic took;
        int   stall_cnt;
        int   first;
        logic [W-1:0] pend[$];

        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_carry", out_carry, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_stat_xfers", stat_xfers, 0);
        chk("rst_stat_carries", stat_carries, 0);
        @(negedge clk);
        rst_n = 1'b1;

        latency_beat(16'hFFFF, 16'h0001, "wrap");
        drain();

        cycle(1'b1, 16'hFFF0, 16'h0020, 2'b01, 1'b0, 1'b1, took);
        cycle(1'b1, 16'h0005, 16'h0007, 2'b10, 1'b0, 1'b1, took);
        cycle(1'b1, 16'h0007, 16'h0005, 2'b10, 1'b0, 1'b1, took);
        drain();

        cycle(1'b0, '0, '0, 2'b00, 1'b1, 1'b1, took);
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'h1000, 16'h0, 2'b11, 1'b0, 1'b1, took);
        cycle(1'b1, 16'h1000, 16'h0, 2'b11, 1'b1, 1'b1, took);
        drain();

        // Backpressure: 6 beats, out_ready low for the 3 cycles starting at the first out_valid.
        for (int i = 1; i <= 6; i++) pend.push_back(i[W-1:0]);
        stall_cnt = 0;
        first = -1;
        for (int cyc = 0; cyc < 40 && (pend.size() != 0 || exp_q.size() != 0); cyc++) begin
            if (first < 0 && out_valid) first = cyc;
            cycle(pend.size() != 0, (pend.size() != 0) ? pend[0] : '0, '0, 2'b00, 1'b0,
                  !(first >= 0 && cyc >= first && cyc <= first + 2), took);
            if (pend.size() != 0) begin
                if (took) void'(pend.pop_front());
                else stall_cnt++;
            end
        end
        chk("bp_stall_cycles", stall_cnt, 3);
        chk("bp_all_out", exp_q.size(), 0);

        // Reset with two beats in flight.
        cycle(1'b1, 16'h0011, 16'h0001, 2'b00, 1'b0, 1'b0, took);
        cycle(1'b1, 16'h0022, 16'h0001, 2'b00, 1'b0, 1'b0, took);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        exp_q.delete();
        macc = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) cycle(1'b0, '0, '0, 2'b00, 1'b0, 1'b1, took);
        latency_beat(16'h1234, 16'h0001, "post_rst");
        drain();

        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 4) != 0, $urandom, $urandom, $urandom % 4,
                  ($urandom % 8) == 0, ($urandom % 4) != 0, took);
        end
        drain();

        // Stats: fresh counters, 10 beats, 3 with carry.
        @(negedge clk);
        #3 rst_n = 1'b0;
        macc = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i % 3 == 0 && i < 9) cycle(1'b1, 16'hFFFF, 16'h0001, 2'b00, 1'b0, 1'b1, took);
            else cycle(1'b1, 16'h0001, 16'h0001, 2'b00, 1'b0, 1'b1, took);
        end
        drain();
`ifdef PIPE_ADDER_STATS_EN
        chk("stat_xfers", stat_xfers, 10);
        chk("stat_carries", stat_carries, 3);
`else
        chk("stat_xfers", stat_xfers, 0);
        chk("stat_carries", stat_carries, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
